// File: rtl/spart_driver.sv
// Bus master for the SPART: programs the baud divisor from br_cfg, then echoes
// every received byte back out. All bus outputs come straight from flops.
module spart_driver #(
  parameter int CLK_FREQ = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  br_cfg,
  input  logic        rda,
  input  logic        tbr,
  output logic        iocs,
  output logic        iorw,
  output logic [1:0]  ioaddr,
  inout  wire  [7:0]  databus,
  output logic [15:0] echo_cnt
);

  localparam logic [15:0] DIV_4800  = 16'(CLK_FREQ / (16 * 4800) - 1);
  localparam logic [15:0] DIV_9600  = 16'(CLK_FREQ / (16 * 9600) - 1);
  localparam logic [15:0] DIV_19200 = 16'(CLK_FREQ / (16 * 19200) - 1);
  localparam logic [15:0] DIV_38400 = 16'(CLK_FREQ / (16 * 38400) - 1);

  typedef enum logic [2:0] {
    LOAD_LO, LOAD_HI, IDLE, READ, WAIT_TBR, WRITE
  } state_t;

  state_t      state_q, state_d;
  logic        boot_q, boot_d;
  logic [1:0]  cfg_q, cfg_d;
  logic [7:0]  char_q, char_d;
  logic [15:0] cnt_q, cnt_d;
  logic        iocs_q, iocs_d;
  logic        iorw_q, iorw_d;
  logic [1:0]  addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic [15:0] div;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD_LO;
      boot_q  <= 1'b1;
      cfg_q   <= 2'b00;
      char_q  <= 8'h00;
      cnt_q   <= 16'h0000;
      iocs_q  <= 1'b0;
      iorw_q  <= 1'b1;
      addr_q  <= 2'b00;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      cfg_q   <= cfg_d;
      char_q  <= char_d;
      cnt_q   <= cnt_d;
      iocs_q  <= iocs_d;
      iorw_q  <= iorw_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
    end
  end

  // The first edge after reset only latches br_cfg and launches the LOAD_LO
  // access, so the divisor written always matches the sampled switches.
  always_comb begin
    state_d = state_q;
    boot_d  = 1'b0;
    cfg_d   = cfg_q;
    char_d  = char_q;
    cnt_d   = cnt_q;
    if (boot_q) begin
      cfg_d   = br_cfg;
      state_d = LOAD_LO;
    end else begin
      case (state_q)
        LOAD_LO:  state_d = LOAD_HI;
        LOAD_HI:  state_d = IDLE;
        IDLE: begin
          if (br_cfg != cfg_q) begin
            cfg_d   = br_cfg;
            state_d = LOAD_LO;
          end else if (rda) begin
            state_d = READ;
          end
        end
        READ: begin
          char_d  = databus;
          state_d = WAIT_TBR;
        end
        WAIT_TBR: if (tbr) state_d = WRITE;
        WRITE: begin
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          state_d = IDLE;
        end
        default:  state_d = LOAD_LO;
      endcase
    end
  end

  always_comb begin
    case (cfg_d)
      2'b00:   div = DIV_4800;
      2'b01:   div = DIV_9600;
      2'b10:   div = DIV_19200;
      default: div = DIV_38400;
    endcase
  end

  // Output flops load the values of the access that state_d is about to run.
  always_comb begin
    iocs_d = 1'b0;
    iorw_d = 1'b1;
    addr_d = 2'b00;
    dout_d = 8'h00;
    case (state_d)
      LOAD_LO: begin
        iocs_d = 1'b1; iorw_d = 1'b0; addr_d = 2'b10; dout_d = div[7:0];
      end
      LOAD_HI: begin
        iocs_d = 1'b1; iorw_d = 1'b0; addr_d = 2'b11; dout_d = div[15:8];
      end
      READ: begin
        iocs_d = 1'b1; iorw_d = 1'b1; addr_d = 2'b00;
      end
      WRITE: begin
        iocs_d = 1'b1; iorw_d = 1'b0; addr_d = 2'b00; dout_d = char_q;
      end
      default: ;
    endcase
  end

  assign iocs     = iocs_q;
  assign iorw     = iorw_q;
  assign ioaddr   = addr_q;
  assign echo_cnt = cnt_q;
  assign databus  = (iocs_q && !iorw_q) ? dout_q : 8'hzz;

endmodule
